// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int unsigned DefaultWidth = 10;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Counter must hold N itself, hence N+1 distinct values.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_iterative_if.sv
// Request/result bundle of the iterative divider; master drives operands, slave returns results.
interface div_iterative_if
  import div_pkg::*;
#(
  parameter int unsigned N = DefaultWidth
);

  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         busy;
  logic         done;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         dz;

  modport master (
    output start, x, y,
    input  busy, done, q, r, dz
  );

  modport slave (
    input  start, x, y,
    output busy, done, q, r, dz
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: trial subtract, keep or restore the remainder.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned N = DefaultWidth
) (
  input  logic [N:0]   p_i,
  input  logic         bit_i,
  input  logic [N-1:0] d_i,
  output logic [N:0]   p_o,
  output logic         q_o
);

  logic [N:0] shifted;
  logic [N:0] trial;

  always_comb begin
    shifted = {p_i[N-1:0], bit_i};
    trial   = shifted - {1'b0, d_i};
    // A set p_i[N] means the shifted value already exceeds any N-bit divisor.
    q_o     = p_i[N] | ~trial[N];
    p_o     = q_o ? trial : shifted;
  end

endmodule

// File: rtl/div_iterative.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_CHECK_EN: a zero divisor finishes at once and raises dz.
module div_iterative
  import div_pkg::*;
#(
  parameter int unsigned N = DefaultWidth
) (
  input logic            clk,
  input logic            rst,
  div_iterative_if.slave div_io
);

  localparam int unsigned CntW = cnt_width(N);

  state_e          state_q, state_d;
  logic [N:0]      p_q, p_d, p_step;
  logic [N-1:0]    qreg_q, qreg_d;
  logic [N-1:0]    d_q, d_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    r_q, r_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            q_bit;
  logic            accept;
  logic            zero;
  logic            last;
`ifdef DIV_ZERO_CHECK_EN
  logic            dz_q, dz_d;
`endif

  assign accept = div_io.start && (state_q != StRun);
  assign last   = (state_q == StRun) && (cnt_q == CntW'(1));
`ifdef DIV_ZERO_CHECK_EN
  assign zero   = (div_io.y == '0);
`else
  assign zero   = 1'b0;
`endif

  div_step #(.N(N)) u_step (
    .p_i   (p_q),
    .bit_i (qreg_q[N-1]),
    .d_i   (d_q),
    .p_o   (p_step),
    .q_o   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = accept ? (zero ? StDone : StRun) : StIdle;
      StRun:          if (last) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      qreg_q <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
`ifdef DIV_ZERO_CHECK_EN
      dz_q   <= 1'b0;
`endif
    end else begin
      p_q    <= p_d;
      qreg_q <= qreg_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      r_q    <= r_d;
`ifdef DIV_ZERO_CHECK_EN
      dz_q   <= dz_d;
`endif
    end
  end

  always_comb begin
    p_d    = p_q;
    qreg_d = qreg_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    r_d    = r_q;
`ifdef DIV_ZERO_CHECK_EN
    dz_d   = dz_q;
`endif
    if (accept) begin
      p_d    = '0;
      qreg_d = div_io.x;
      d_d    = div_io.y;
      cnt_d  = CntW'(N);
`ifdef DIV_ZERO_CHECK_EN
      dz_d   = zero;
      if (zero) begin
        q_d = '1;
        r_d = div_io.x;
      end
`endif
    end else if (state_q == StRun) begin
      p_d    = p_step;
      qreg_d = {qreg_q[N-2:0], q_bit};
      cnt_d  = cnt_q - CntW'(1);
      if (last) begin
        q_d = {qreg_q[N-2:0], q_bit};
        r_d = p_step[N-1:0];
      end
    end
  end

  always_comb begin
    div_io.busy = (state_q == StRun);
    div_io.done = (state_q == StDone);
    div_io.q    = q_q;
    div_io.r    = r_q;
`ifdef DIV_ZERO_CHECK_EN
    div_io.dz   = dz_q;
`else
    div_io.dz   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_div_iterative.sv
// Directed bench for div_iterative (N=10); expectations follow DIV_ZERO_CHECK_EN when defined.
module tb_div_iterative;

  localparam int unsigned N = 10;
`ifdef DIV_ZERO_CHECK_EN
  localparam int ZeroLat = 0;
  localparam bit ZeroDz  = 1'b1;
`else
  localparam int ZeroLat = 10;
  localparam bit ZeroDz  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  div_iterative_if #(.N(N)) bus ();

  div_iterative #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_io (bus)
  );

  always #5 clk = ~clk;

  // Returns at the falling edge just after the edge that samples start.
  task automatic start_op(input logic [N-1:0] xv, input logic [N-1:0] yv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = xv;
    bus.y     = yv;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int c, output int nb);
    c  = 0;
    nb = 0;
    while (!bus.done && c < 40) begin
      if (bus.busy) nb++;
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
    n_total++;
    if (bus.q !== 10'd0) $display("FAIL reset_q: got %0d want 0", bus.q); else n_pass++;
    n_total++;
    if (bus.r !== 10'd0) $display("FAIL reset_r: got %0d want 0", bus.r); else n_pass++;
    n_total++;
    if (bus.dz !== 1'b0) $display("FAIL reset_dz: got %b want 0", bus.dz); else n_pass++;
  endtask

  task automatic test_basic();
    int c, nb;
    start_op(10'd100, 10'd7);
    wait_done(c, nb);
    n_total++;
    if (c != 10) $display("FAIL basic_latency: got %0d want 10", c); else n_pass++;
    n_total++;
    if (nb != 10) $display("FAIL basic_busy_cycles: got %0d want 10", nb); else n_pass++;
    n_total++;
    if (bus.q !== 10'd14) $display("FAIL basic_q: got %0d want 14", bus.q); else n_pass++;
    n_total++;
    if (bus.r !== 10'd2) $display("FAIL basic_r: got %0d want 2", bus.r); else n_pass++;
    n_total++;
    if (bus.dz !== 1'b0) $display("FAIL basic_dz: got %b want 0", bus.dz); else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", bus.done); else n_pass++;
    n_total++;
    if (bus.q !== 10'd14) $display("FAIL basic_q_hold: got %0d want 14", bus.q); else n_pass++;
  endtask

  task automatic test_vectors();
    int vx[4] = '{1023, 0, 3, 1000};
    int vy[4] = '{1, 5, 1000, 3};
    int eq[4] = '{1023, 0, 0, 333};
    int er[4] = '{0, 0, 3, 1};
    logic [N-1:0] xv, yv, qe, re;
    int c, nb;
    for (int i = 0; i < 4; i++) begin
      xv = vx[i][N-1:0];
      yv = vy[i][N-1:0];
      qe = eq[i][N-1:0];
      re = er[i][N-1:0];
      start_op(xv, yv);
      wait_done(c, nb);
      n_total++;
      if (c != 10) $display("FAIL vec%0d_latency: got %0d want 10", i, c); else n_pass++;
      n_total++;
      if (bus.q !== qe) $display("FAIL vec%0d_q: got %0d want %0d", i, bus.q, qe); else n_pass++;
      n_total++;
      if (bus.r !== re) $display("FAIL vec%0d_r: got %0d want %0d", i, bus.r, re); else n_pass++;
    end
  endtask

  task automatic test_div_zero();
    int c, nb;
    start_op(10'd5, 10'd0);
    wait_done(c, nb);
    n_total++;
    if (c != ZeroLat) $display("FAIL dz_latency: got %0d want %0d", c, ZeroLat); else n_pass++;
    n_total++;
    if (nb != ZeroLat) $display("FAIL dz_busy_cycles: got %0d want %0d", nb, ZeroLat);
    else n_pass++;
    n_total++;
    if (bus.q !== 10'd1023) $display("FAIL dz_q: got %0d want 1023", bus.q); else n_pass++;
    n_total++;
    if (bus.r !== 10'd5) $display("FAIL dz_r: got %0d want 5", bus.r); else n_pass++;
    n_total++;
    if (bus.dz !== ZeroDz) $display("FAIL dz_flag: got %b want %b", bus.dz, ZeroDz); else n_pass++;
    start_op(10'd8, 10'd2);
    wait_done(c, nb);
    n_total++;
    if (bus.dz !== 1'b0) $display("FAIL dz_clear: got %b want 0", bus.dz); else n_pass++;
    n_total++;
    if (bus.q !== 10'd4) $display("FAIL dz_next_q: got %0d want 4", bus.q); else n_pass++;
  endtask

  task automatic test_ignore_start();
    int c;
    start_op(10'd200, 10'd9);
    c = 0;
    while (!bus.done && c < 40) begin
      if (c == 3) begin
        bus.start = 1'b1;
        bus.x     = 10'd50;
        bus.y     = 10'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    bus.start = 1'b0;
    n_total++;
    if (c != 10) $display("FAIL ignore_latency: got %0d want 10", c); else n_pass++;
    n_total++;
    if (bus.q !== 10'd22) $display("FAIL ignore_q: got %0d want 22", bus.q); else n_pass++;
    n_total++;
    if (bus.r !== 10'd2) $display("FAIL ignore_r: got %0d want 2", bus.r); else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL ignore_no_restart: got %b want 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ndone;
    start_op(10'd500, 10'd3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", bus.done); else n_pass++;
    n_total++;
    if (bus.q !== 10'd0) $display("FAIL rstmid_q: got %0d want 0", bus.q); else n_pass++;
    n_total++;
    if (bus.r !== 10'd0) $display("FAIL rstmid_r: got %0d want 0", bus.r); else n_pass++;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    n_total++;
    if (ndone != 0) $display("FAIL rstmid_quiet: got %0d active cycles want 0", ndone);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c, nb, g;
    start_op(10'd100, 10'd7);
    wait_done(c, nb);
    n_total++;
    if (bus.q !== 10'd14) $display("FAIL b2b_first_q: got %0d want 14", bus.q); else n_pass++;
    n_total++;
    if (bus.r !== 10'd2) $display("FAIL b2b_first_r: got %0d want 2", bus.r); else n_pass++;
    bus.start = 1'b1;
    bus.x     = 10'd77;
    bus.y     = 10'd8;
    @(negedge clk);
    bus.start = 1'b0;
    g = 1;
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", bus.busy); else n_pass++;
    while (!bus.done && g < 40) begin
      @(negedge clk);
      g++;
    end
    n_total++;
    if (g != 11) $display("FAIL b2b_gap: got %0d want 11", g); else n_pass++;
    n_total++;
    if (bus.q !== 10'd9) $display("FAIL b2b_q: got %0d want 9", bus.q); else n_pass++;
    n_total++;
    if (bus.r !== 10'd5) $display("FAIL b2b_r: got %0d want 5", bus.r); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
